greenhouse_zone_ctrl: RTL and testbench
=======================================

# greenhouse_zone_ctrl

Multi-zone successor to the single-zone greenhouse monitor. It accepts time-multiplexed sensor samples tagged with a zone number and keeps per-zone fan, irrigation and humidity-control state. Each actuator has hysteresis thresholds and a minimum-dwell anti-chatter timer, a per-zone auto/remote mode, and a persistence-filtered pest alert. It sits between the sensor scan sequencer and the actuator drivers.

## Interface
Parameters:
- ZONES, 4, number of zones (1..16)
- W, 8, sensor sample width
- TEMP_HI, 30, fan turn-on threshold (strict >)
- TEMP_LO, 27, fan turn-off threshold (strict <); must be < TEMP_HI
- MOIST_LO, 30, irrigation turn-on threshold (strict <)
- MOIST_HI, 45, irrigation turn-off threshold (strict >); must be > MOIST_LO
- HUM_HI, 70, humidity-control turn-on threshold (strict >)
- HUM_LO, 60, humidity-control turn-off threshold (strict <); must be < HUM_HI
- PEST_MAX, 100, pest alarm level (>=)
- MIN_DWELL, 16, minimum clk cycles between toggles of one actuator
- ALERT_PERSIST, 4, consecutive alarming samples required to raise alert

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  sample bus holds a valid sample this cycle
- zone_sel  in  ZW=max(1,$clog2(ZONES))  zone the sample belongs to
- temperature  in  W  unsigned
- humidity  in  W  unsigned
- soil_moisture  in  W  unsigned
- pest_level  in  W  unsigned
- remote_mode  in  ZONES  per zone: 1 = remote override, 0 = auto
- remote_fan, remote_irrigation, remote_humidity_control  in  ZONES each  override commands
- fan, irrigation, humidity_control  out  ZONES each  actuator drives, registered
- alert  out  ZONES  per-zone pest alert, registered
- alert_any  out  1  OR of alert, registered

## Operation
- Per zone and per actuator there is a 2-state FSM (OFF/ON) plus a dwell counter. The counter width is $clog2(MIN_DWELL+1). It increments every cycle, saturates at MIN_DWELL, and clears to 0 when its actuator toggles. The dwell has expired when the counter equals MIN_DWELL.
- Auto mode, on sample_valid with a valid zone_sel = z, evaluate zone z only:
  - fan: OFF->ON if temperature > TEMP_HI and dwell expired; ON->OFF if temperature < TEMP_LO and dwell expired.
  - irrigation: OFF->ON if soil_moisture < MOIST_LO; ON->OFF if soil_moisture > MOIST_HI. Same dwell rule.
  - humidity_control: OFF->ON if humidity > HUM_HI; ON->OFF if humidity < HUM_LO. Same dwell rule.
  - Otherwise the state holds. A condition that is blocked by dwell is dropped, not queued.
- Remote mode (remote_mode[z]=1), every cycle regardless of sample_valid:
  - Each actuator state is loaded from its remote_* bit, ignoring dwell.
  - The dwell counter clears whenever the loaded value differs from the current state.
  - Samples for the zone still update the alert path.
- Mode change 1->0: the FSM continues from its current state and the dwell counter is not touched.
- Alert: each zone has a persistence counter, width $clog2(ALERT_PERSIST+1).
  - On a sample for zone z, the counter increments (saturating at ALERT_PERSIST) if pest_level >= PEST_MAX; otherwise it clears.
  - alert[z] = (counter == ALERT_PERSIST).
- Samples with zone_sel >= ZONES are ignored entirely.
- Zones not addressed by the current sample are untouched, apart from dwell counting and remote loading.

## Timing
- Reset: all FSMs OFF, all dwell counters = MIN_DWELL (so the first toggle is immediate), all alert counters 0. All outputs are 0 on the cycle after the rst edge.
- rst asserted mid-operation overrides sample_valid in the same cycle.
- Latency: a sample in cycle N produces its output change at edge N+1. A remote_* change in cycle N is visible at N+1.
- alert falls at N+1 after the first non-alarming sample. alert_any follows alert in the same cycle.
- sample_valid may be asserted every cycle; there is no backpressure.
- Back-to-back samples to the same zone are each evaluated against the state updated by the previous sample.
- Boundaries: temperature == TEMP_HI gives no turn-on; temperature == TEMP_LO leaves the fan ON. Equivalent rules apply at the other thresholds.
- Comparisons are unsigned W-bit. No counter wraps.

## Test plan
- Dwell and hysteresis: after reset, zone 0 temp=31 -> fan[0]=1 next cycle. Then temp=26 two cycles later -> fan stays 1. Then temp=26 after 16 cycles since the turn-on -> fan[0]=0.
- Hysteresis edges: zone 1 temp=30 -> fan[1]=0. Then temp=31 -> 1. Then temp=27 (dwell expired) -> stays 1. Then temp=26 -> 0.
- Multi-zone isolation: interleave zone 2 moisture=20 and zone 3 moisture=50 -> only irrigation[2]=1. A sample with zone_sel beyond ZONES (ZONES=3 build, zone_sel=3) -> no state change.
- Alert persistence: zone 0 pest=100 for 3 samples -> alert[0]=0. The 4th sample -> alert[0]=1 and alert_any=1. pest=99 -> both 0 next cycle.
- Remote override: remote_mode[1]=1 with remote_humidity_control[1] toggling every cycle -> output follows with 1-cycle latency, no dwell. Release remote with humidity=80 right after a toggle -> no turn-on until 16 cycles have elapsed.
- Reset mid-operation: all actuators ON and alert[2]=1, assert rst together with sample_valid -> all outputs 0 next cycle. A first sample temp=31 after reset -> fan ON immediately.

Source files
------------

// File: rtl/greenhouse_zone_ctrl_if.sv
// Sample bus from the sensor scan sequencer into the zone controller.
// One zone-tagged sample per cycle; there is no backpressure.
interface greenhouse_zone_ctrl_if #(
    parameter int ZONES = 4,
    parameter int W     = 8
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

    logic          sample_valid;
    logic [ZW-1:0] zone_sel;
    logic [W-1:0]  temperature;
    logic [W-1:0]  humidity;
    logic [W-1:0]  soil_moisture;
    logic [W-1:0]  pest_level;

    modport master (
        output sample_valid,
        output zone_sel,
        output temperature,
        output humidity,
        output soil_moisture,
        output pest_level
    );

    modport slave (
        input sample_valid,
        input zone_sel,
        input temperature,
        input humidity,
        input soil_moisture,
        input pest_level
    );
endinterface

// File: rtl/greenhouse_zone_ctrl.sv
// Multi-zone greenhouse controller: per-zone fan, irrigation and humidity
// FSMs with hysteresis, anti-chatter dwell, remote override and pest alert.
module greenhouse_zone_ctrl #(
    parameter int ZONES         = 4,
    parameter int W             = 8,
    parameter int TEMP_HI       = 30,
    parameter int TEMP_LO       = 27,
    parameter int MOIST_LO      = 30,
    parameter int MOIST_HI      = 45,
    parameter int HUM_HI        = 70,
    parameter int HUM_LO        = 60,
    parameter int PEST_MAX      = 100,
    parameter int MIN_DWELL     = 16,
    parameter int ALERT_PERSIST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    greenhouse_zone_ctrl_if.slave    smp,
    input  logic [ZONES-1:0]         remote_mode,
    input  logic [ZONES-1:0]         remote_fan,
    input  logic [ZONES-1:0]         remote_irrigation,
    input  logic [ZONES-1:0]         remote_humidity_control,
    output logic [ZONES-1:0]         fan,
    output logic [ZONES-1:0]         irrigation,
    output logic [ZONES-1:0]         humidity_control,
    output logic [ZONES-1:0]         alert,
    output logic                     alert_any
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int AW = $clog2(ALERT_PERSIST + 1);
    localparam logic [DW-1:0] DWELL_MAX   = DW'(MIN_DWELL);
    localparam logic [AW-1:0] PERSIST_MAX = AW'(ALERT_PERSIST);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } act_e;

    // Actuator index 0 = fan, 1 = irrigation, 2 = humidity control.
    act_e          st_q    [ZONES][3];
    act_e          st_d    [ZONES][3];
    logic [DW-1:0] dwell_q [ZONES][3];
    logic [DW-1:0] dwell_d [ZONES][3];
    logic [AW-1:0] acnt_q  [ZONES];
    logic [AW-1:0] acnt_d  [ZONES];
    logic [ZONES-1:0] alert_q;
    logic [ZONES-1:0] alert_d;
    logic             alert_any_q;
    logic             alert_any_d;

    logic [2:0] on_c;
    logic [2:0] off_c;
    logic [2:0] rcmd;
    logic       hit;
    logic       expired;
    act_e       nxt;

    always_comb begin
        on_c = {smp.humidity > W'(HUM_HI),
                smp.soil_moisture < W'(MOIST_LO),
                smp.temperature > W'(TEMP_HI)};
        off_c = {smp.humidity < W'(HUM_LO),
                 smp.soil_moisture > W'(MOIST_HI),
                 smp.temperature < W'(TEMP_LO)};
        hit     = 1'b0;
        rcmd    = '0;
        expired = 1'b0;
        nxt     = OFF;
        st_d    = st_q;
        dwell_d = dwell_q;
        acnt_d  = acnt_q;
        alert_d = '0;
        for (int z = 0; z < ZONES; z++) begin
            // Out-of-range zone_sel never matches any zone.
            hit  = smp.sample_valid && (smp.zone_sel == ZW'(z));
            rcmd = {remote_humidity_control[z],
                    remote_irrigation[z],
                    remote_fan[z]};
            for (int a = 0; a < 3; a++) begin
                expired = (dwell_q[z][a] == DWELL_MAX);
                nxt     = st_q[z][a];
                if (remote_mode[z]) begin
                    nxt = act_e'(rcmd[a]);
                end else if (hit && expired) begin
                    unique case (st_q[z][a])
                        OFF: if (on_c[a]) nxt = ON;
                        ON:  if (off_c[a]) nxt = OFF;
                        default: ;
                    endcase
                end
                st_d[z][a] = nxt;
                if (nxt != st_q[z][a]) begin
                    dwell_d[z][a] = '0;
                end else if (!expired) begin
                    dwell_d[z][a] = dwell_q[z][a] + 1'b1;
                end
            end
            if (hit) begin
                if (smp.pest_level >= W'(PEST_MAX)) begin
                    if (acnt_q[z] != PERSIST_MAX) begin
                        acnt_d[z] = acnt_q[z] + 1'b1;
                    end
                end else begin
                    acnt_d[z] = '0;
                end
            end
            alert_d[z] = (acnt_d[z] == PERSIST_MAX);
        end
        alert_any_d = |alert_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int z = 0; z < ZONES; z++) begin
                for (int a = 0; a < 3; a++) begin
                    st_q[z][a]    <= OFF;
                    dwell_q[z][a] <= DWELL_MAX;
                end
                acnt_q[z] <= '0;
            end
            alert_q     <= '0;
            alert_any_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            dwell_q     <= dwell_d;
            acnt_q      <= acnt_d;
            alert_q     <= alert_d;
            alert_any_q <= alert_any_d;
        end
    end

    always_comb begin
        fan              = '0;
        irrigation       = '0;
        humidity_control = '0;
        for (int z = 0; z < ZONES; z++) begin
            fan[z]              = (st_q[z][0] == ON);
            irrigation[z]       = (st_q[z][1] == ON);
            humidity_control[z] = (st_q[z][2] == ON);
        end
    end

    assign alert     = alert_q;
    assign alert_any = alert_any_q;
endmodule

// File: tb/tb_greenhouse_zone_ctrl.sv
// Bench for greenhouse_zone_ctrl (3-zone build, so zone_sel=3 is out of range).
// Directed scenarios plus random traffic against a timestamp-based model.
module tb_greenhouse_zone_ctrl;
    localparam int ZONES         = 3;
    localparam int W             = 8;
    localparam int ZW            = 2;
    localparam int TEMP_HI       = 30;
    localparam int TEMP_LO       = 27;
    localparam int MOIST_LO      = 30;
    localparam int MOIST_HI      = 45;
    localparam int HUM_HI        = 70;
    localparam int HUM_LO        = 60;
    localparam int PEST_MAX      = 100;
    localparam int MIN_DWELL     = 16;
    localparam int ALERT_PERSIST = 4;

    logic clk = 1'b0;
    logic rst;
    logic          sample_valid;
    logic [ZW-1:0] zone_sel;
    logic [W-1:0]  temperature;
    logic [W-1:0]  humidity;
    logic [W-1:0]  soil_moisture;
    logic [W-1:0]  pest_level;
    logic [ZONES-1:0] remote_mode;
    logic [ZONES-1:0] remote_fan;
    logic [ZONES-1:0] remote_irrigation;
    logic [ZONES-1:0] remote_humidity_control;
    logic [ZONES-1:0] fan;
    logic [ZONES-1:0] irrigation;
    logic [ZONES-1:0] humidity_control;
    logic [ZONES-1:0] alert;
    logic             alert_any;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    greenhouse_zone_ctrl_if #(.ZONES(ZONES), .W(W)) bus ();

    assign bus.sample_valid  = sample_valid;
    assign bus.zone_sel      = zone_sel;
    assign bus.temperature   = temperature;
    assign bus.humidity      = humidity;
    assign bus.soil_moisture = soil_moisture;
    assign bus.pest_level    = pest_level;

    greenhouse_zone_ctrl #(
        .ZONES(ZONES), .W(W),
        .TEMP_HI(TEMP_HI), .TEMP_LO(TEMP_LO),
        .MOIST_LO(MOIST_LO), .MOIST_HI(MOIST_HI),
        .HUM_HI(HUM_HI), .HUM_LO(HUM_LO),
        .PEST_MAX(PEST_MAX), .MIN_DWELL(MIN_DWELL),
        .ALERT_PERSIST(ALERT_PERSIST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .smp(bus.slave),
        .remote_mode(remote_mode),
        .remote_fan(remote_fan),
        .remote_irrigation(remote_irrigation),
        .remote_humidity_control(remote_humidity_control),
        .fan(fan),
        .irrigation(irrigation),
        .humidity_control(humidity_control),
        .alert(alert),
        .alert_any(alert_any)
    );

    // Model: actuator on/off, edge of last toggle, run of alarming samples.
    bit m_on   [ZONES][3];
    int m_last [ZONES][3];
    int m_run  [ZONES];
    int edge_n = 0;

    function automatic void model_step();
        bit want;
        bit hit;
        bit onc [3];
        bit offc [3];
        bit rem [3];
        int t;
        int h;
        int m;
        int p;
        edge_n++;
        t = int'(temperature);
        h = int'(humidity);
        m = int'(soil_moisture);
        p = int'(pest_level);
        onc[0]  = t > TEMP_HI;
        offc[0] = t < TEMP_LO;
        onc[1]  = m < MOIST_LO;
        offc[1] = m > MOIST_HI;
        onc[2]  = h > HUM_HI;
        offc[2] = h < HUM_LO;
        for (int z = 0; z < ZONES; z++) begin
            if (rst) begin
                for (int a = 0; a < 3; a++) begin
                    m_on[z][a]   = 1'b0;
                    m_last[z][a] = -1000;
                end
                m_run[z] = 0;
            end else begin
                hit = sample_valid && (int'(zone_sel) == z);
                rem[0] = remote_fan[z];
                rem[1] = remote_irrigation[z];
                rem[2] = remote_humidity_control[z];
                for (int a = 0; a < 3; a++) begin
                    want = m_on[z][a];
                    if (remote_mode[z]) begin
                        want = rem[a];
                    end else if (hit &&
                        (edge_n - 1 - m_last[z][a]) >= MIN_DWELL) begin
                        if (!m_on[z][a] && onc[a]) want = 1'b1;
                        else if (m_on[z][a] && offc[a]) want = 1'b0;
                    end
                    if (want != m_on[z][a]) begin
                        m_on[z][a]   = want;
                        m_last[z][a] = edge_n;
                    end
                end
                if (hit) begin
                    if (p >= PEST_MAX) m_run[z] = (m_run[z] < 1000) ? m_run[z] + 1 : m_run[z];
                    else m_run[z] = 0;
                end
            end
        end
    endfunction

    function automatic logic [ZONES-1:0] m_vec(int a);
        logic [ZONES-1:0] v;
        for (int z = 0; z < ZONES; z++) v[z] = m_on[z][a];
        return v;
    endfunction

    function automatic logic [ZONES-1:0] m_alert();
        logic [ZONES-1:0] v;
        for (int z = 0; z < ZONES; z++) v[z] = (m_run[z] >= ALERT_PERSIST);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(int z, int t, int h, int m, int p);
        sample_valid  = 1'b1;
        zone_sel      = ZW'(z);
        temperature   = W'(t);
        humidity      = W'(h);
        soil_moisture = W'(m);
        pest_level    = W'(p);
    endtask

    task automatic idle();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive(0, 28, 65, 40, 0);
        sample_valid = 1'b0;
        remote_mode = '0;
        remote_fan = '0;
        remote_irrigation = '0;
        remote_humidity_control = '0;
        tick();
        n_checks++;
        if ({fan, irrigation, humidity_control, alert, alert_any} !== 13'd0)
            $display("FAIL reset_outputs: got %b expected all 0",
                     {fan, irrigation, humidity_control, alert, alert_any});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_dwell_hysteresis();
        drive(0, 31, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[0] !== 1'b1) $display("FAIL dwell_first_on: fan[0]=%b expected 1", fan[0]);
        else n_pass++;
        idle();
        tick();
        drive(0, 26, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[0] !== 1'b1) $display("FAIL dwell_block_early: fan[0]=%b expected 1", fan[0]);
        else n_pass++;
        idle();
        repeat (13) tick();
        drive(0, 26, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[0] !== 1'b1) $display("FAIL dwell_block_15: fan[0]=%b expected 1", fan[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (fan[0] !== 1'b0) $display("FAIL dwell_expired_off: fan[0]=%b expected 0", fan[0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_hysteresis_edges();
        drive(1, 30, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[1] !== 1'b0) $display("FAIL hyst_eq_hi: fan[1]=%b expected 0", fan[1]);
        else n_pass++;
        drive(1, 31, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[1] !== 1'b1) $display("FAIL hyst_above_hi: fan[1]=%b expected 1", fan[1]);
        else n_pass++;
        idle();
        repeat (17) tick();
        drive(1, 27, 65, 40, 0);
        tick();
        n_checks++;
        if (fan[1] !== 1'b1) $display("FAIL hyst_eq_lo: fan[1]=%b expected 1", fan[1]);
        else n_pass++;
        drive(1, 26, 65, 40, 0);
        tick();
        n_checks++;
        if (fan !== 3'b000) $display("FAIL hyst_below_lo: fan=%b expected 000", fan);
        else n_pass++;
        idle();
    endtask

    task automatic test_isolation();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(2, 28, 65, 20, 0);
            else drive(3, 28, 65, 50, 0);
            tick();
            n_checks++;
            if (irrigation !== 3'b100)
                $display("FAIL iso_irrigation_%0d: irrigation=%b expected 100", i, irrigation);
            else n_pass++;
        end
        drive(3, 31, 80, 20, 200);
        tick();
        n_checks++;
        if ({fan, irrigation, humidity_control, alert, alert_any} !== 13'b000_100_000_000_0)
            $display("FAIL iso_out_of_range: got %b expected 0001000000000",
                     {fan, irrigation, humidity_control, alert, alert_any});
        else n_pass++;
        idle();
    endtask

    task automatic test_alert();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 28, 65, 40, 100);
            tick();
            n_checks++;
            if ({alert[0], alert_any} !== ((i == 4) ? 2'b11 : 2'b00))
                $display("FAIL alert_persist_%0d: alert[0],any=%b expected %b",
                         i, {alert[0], alert_any}, (i == 4) ? 2'b11 : 2'b00);
            else n_pass++;
        end
        drive(0, 28, 65, 40, 99);
        tick();
        n_checks++;
        if ({alert[0], alert_any} !== 2'b00)
            $display("FAIL alert_fall: alert[0],any=%b expected 00", {alert[0], alert_any});
        else n_pass++;
        idle();
    endtask

    task automatic test_remote();
        idle();
        remote_fan = '0;
        remote_irrigation = '0;
        remote_mode = 3'b010;
        for (int i = 0; i < 6; i++) begin
            remote_humidity_control = (i % 2 == 0) ? 3'b010 : 3'b000;
            tick();
            n_checks++;
            if (humidity_control[1] !== ((i % 2) == 0))
                $display("FAIL remote_follow_%0d: hum[1]=%b expected %b",
                         i, humidity_control[1], (i % 2) == 0);
            else n_pass++;
        end
        remote_mode = '0;
        remote_humidity_control = '0;
        drive(1, 28, 80, 40, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_checks++;
            if (humidity_control[1] !== (k == 17))
                $display("FAIL remote_release_dwell_%0d: hum[1]=%b expected %b",
                         k, humidity_control[1], k == 17);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        repeat (20) tick();
        drive(0, 31, 80, 20, 150);
        tick();
        drive(1, 31, 80, 20, 150);
        tick();
        drive(2, 31, 80, 20, 150);
        repeat (4) tick();
        n_checks++;
        if ({fan, irrigation, humidity_control, alert, alert_any} !== 13'b111_111_111_100_1)
            $display("FAIL mid_all_on: got %b expected 1111111111001",
                     {fan, irrigation, humidity_control, alert, alert_any});
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({fan, irrigation, humidity_control, alert, alert_any} !== 13'd0)
            $display("FAIL mid_reset: got %b expected all 0",
                     {fan, irrigation, humidity_control, alert, alert_any});
        else n_pass++;
        rst = 1'b0;
        drive(0, 31, 65, 40, 0);
        tick();
        n_checks++;
        if (fan !== 3'b001) $display("FAIL mid_first_sample: fan=%b expected 001", fan);
        else n_pass++;
        idle();
    endtask

    task automatic test_random();
        logic [3*ZONES*3+ZONES+1-1:0] got;
        logic [3*ZONES*3+ZONES+1-1:0] exp;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (i % 25 == 0) remote_mode = ZONES'($urandom & $urandom);
            if (i % 3 == 0) begin
                remote_fan = ZONES'($urandom);
                remote_irrigation = ZONES'($urandom);
                remote_humidity_control = ZONES'($urandom);
            end
            drive($urandom_range(0, 3), $urandom_range(24, 34),
                  $urandom_range(56, 74), $urandom_range(26, 49),
                  ($urandom_range(0, 3) != 0) ? $urandom_range(100, 120)
                                              : $urandom_range(90, 99));
            sample_valid = ($urandom_range(0, 3) != 0);
            tick();
            got = '0;
            exp = '0;
            got[12:0] = {fan, irrigation, humidity_control, alert, alert_any};
            exp[12:0] = {m_vec(0), m_vec(1), m_vec(2), m_alert(), |m_alert()};
            n_checks++;
            if (got !== exp)
                $display("FAIL random_%0d: fan,irr,hum,alert,any=%b expected %b",
                         i, got[12:0], exp[12:0]);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_dwell_hysteresis();
        test_hysteresis_edges();
        test_isolation();
        test_alert();
        test_remote();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
